// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: 32 x 32-bit, one write port, two read ports.
// Reg 0 reads as zero; reads bypass a same-cycle write to the same index.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [NUM_REGS-1:0]   write_onehot
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Decode the destination index into one-hot enables; bit 0 never fires.
  always_comb begin
    write_onehot = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      write_onehot[i] = reg_write && (write_reg == ADDR_WIDTH'(i));
    end
  end

  // Next register state: only the enabled register takes write_data.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (write_onehot[i]) begin
        regs_d[i] = write_data;
      end
    end
  end

  // Register array with asynchronous clear; reset wins over a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero for index 0 or during reset, else bypass or array.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (!reset && (read_reg1 != '0)) begin
      read_data1 = write_onehot[read_reg1] ? write_data
                                           : regs_q[read_reg1];
    end
    if (!reset && (read_reg2 != '0)) begin
      read_data2 = write_onehot[read_reg2] ? write_data
                                           : regs_q[read_reg2];
    end
  end

endmodule
